exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
Execution controller for the fetch stage and pipeline. Turns debug-unit commands (RUN, STEP, STOP) into the PC control strobes (start, halt, enable) and the pipeline-wide enable. Detects end of program and counts executed cycles. Sits between the debug/UART command decoder and the pc block.

Parameters:
PC_SIZE, 32, width of PC and breakpoint address
CNT_SIZE, 32, width of executed-cycle counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  command present
i_cmd  in  2  01=RUN, 10=STEP, 11=STOP, 00=NOP (accepted, no effect)
o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready at posedge
i_end_program  in  1  HALT instruction reached writeback
i_pc  in  PC_SIZE  current PC (breakpoint compare only)
o_pc_start  out  1  one-cycle pulse, releases pc from halted state
o_pc_halt  out  1  one-cycle pulse, forces pc to 0
o_enable  out  1  pc/pipeline clock enable
o_busy  out  1  high in START, RUN, STEP_EXEC, HALT
o_done  out  1  one-cycle pulse on entry to DONE
o_cycle_count  out  CNT_SIZE  cycles with o_enable=1 since last START

Behaviour:
- All outputs registered. During reset: state=IDLE, o_cmd_ready=1, every other output 0, counter=0. Reset may be asserted in any state and returns to IDLE immediately.
- States: IDLE, START, RUN, STEP_EXEC, PAUSED, DONE, HALT.
- o_cmd_ready is 1 in IDLE, RUN, PAUSED and DONE; 0 in START, STEP_EXEC and HALT.
- IDLE:
  - RUN -> START with target RUN.
  - STEP -> START with target STEP_EXEC.
  - STOP -> HALT.
- START, 1 cycle:
  - o_pc_start=1, counter cleared to 0, o_enable=0.
  - Next state is the target.
- RUN:
  - o_enable=1 every cycle.
  - i_end_program=1 -> DONE.
  - STOP -> HALT.
  - RUN and STEP are accepted and dropped.
- STEP_EXEC, exactly 1 cycle:
  - o_enable=1.
  - Then PAUSED, or DONE if i_end_program=1 in that cycle.
- PAUSED:
  - o_enable=0.
  - STEP -> STEP_EXEC; RUN -> RUN; STOP -> HALT.
- DONE:
  - o_enable=0; o_done=1 in the first cycle only.
  - STOP -> HALT; RUN and STEP are dropped.
- HALT, 1 cycle:
  - o_pc_halt=1, o_enable=0, counter held.
  - Then IDLE.
- Simultaneous events in RUN: i_end_program and a STOP command in the same cycle -> DONE wins; the STOP is dropped (acknowledged but ignored).
- Counter: increments on every cycle where o_enable=1 and saturates at all-ones (no wrap). Value is visible one cycle after the enabled cycle.
- Latency: command accepted at edge N -> first strobe (start or halt) asserted in cycle N+1; first enabled cycle is N+2.

Optional Feature:
EXEC_CTRL_BREAKPOINT_EN
- Defined: adds ports i_bp_valid (1) and i_bp_addr (PC_SIZE).
- In RUN, when i_bp_valid=1 and i_pc==i_bp_addr with o_enable=1: next state is PAUSED (enable drops the following cycle), and o_done is not pulsed.
- The first RUN cycle after leaving PAUSED ignores the match, so RUN can resume from a breakpoint.
- i_end_program in the same cycle as a match takes priority -> DONE.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset low 5 cycles, release -> all outputs 0, o_cmd_ready=1; RUN -> o_pc_start pulse 1 cycle, then o_enable=1; assert i_end_program after 20 enabled cycles -> o_done pulse, o_enable=0, o_cycle_count=20.
- STEP from IDLE, then 4 more STEPs spaced 3+ cycles -> exactly 5 o_enable pulses of 1 cycle each, o_cycle_count=5, state PAUSED; RUN -> continuous enable.
- RUN 10 cycles, STOP -> o_pc_halt pulse, o_enable=0, o_cycle_count holds 10, back to IDLE with ready=1.
- RUN with STOP and i_end_program in the same cycle -> DONE, no o_pc_halt; following STOP -> o_pc_halt pulse.
- Assert reset mid-RUN -> outputs 0 asynchronously; RUN after release restarts with o_cycle_count from 0.
- (EXEC_CTRL_BREAKPOINT_EN) bp_addr=0x10, i_pc increments by 4 -> pauses after the enabled cycle with i_pc=0x10, no o_done; RUN resumes and does not re-trap on the first cycle.

Source files
------------

// File: rtl/exec_ctrl.sv
// Execution controller: maps RUN/STEP/STOP debug commands onto pc start/halt strobes and the pipeline enable.
// Optional breakpoint support is compiled in with EXEC_CTRL_BREAKPOINT_EN.
module exec_ctrl #(
    parameter int PC_SIZE  = 32,
    parameter int CNT_SIZE = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic                i_end_program,
    input  logic [PC_SIZE-1:0]  i_pc,
`ifdef EXEC_CTRL_BREAKPOINT_EN
    input  logic                i_bp_valid,
    input  logic [PC_SIZE-1:0]  i_bp_addr,
`endif
    output logic                o_pc_start,
    output logic                o_pc_halt,
    output logic                o_enable,
    output logic                o_busy,
    output logic                o_done,
    output logic [CNT_SIZE-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        RUN       = 3'd2,
        STEP_EXEC = 3'd3,
        PAUSED    = 3'd4,
        DONE      = 3'd5,
        HALT      = 3'd6
    } state_t;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    state_t state_r;
    state_t next_state_s;
    state_t target_r;
    state_t next_target_s;
    logic   cmd_fire_s;
    logic   bp_hit_s;

    assign cmd_fire_s = i_cmd_valid & o_cmd_ready;

`ifdef EXEC_CTRL_BREAKPOINT_EN
    logic resume_r;

    // A match is ignored on the first RUN cycle after PAUSED so execution can leave a breakpoint.
    assign bp_hit_s = i_bp_valid & (i_pc == i_bp_addr) & o_enable & ~resume_r;

    // Remember that RUN was just re-entered from PAUSED.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            resume_r <= 1'b0;
        end else begin
            resume_r <= (state_r == PAUSED) && (next_state_s == RUN);
        end
    end
`else
    // Without breakpoints the pc is only folded in so the port is not left dangling.
    assign bp_hit_s = 1'b0 & (^i_pc);
`endif

    // Next-state and start-target selection.
    always_comb begin
        next_state_s  = state_r;
        next_target_s = target_r;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s && (i_cmd == CMD_RUN)) begin
                    next_state_s  = START;
                    next_target_s = RUN;
                end else if (cmd_fire_s && (i_cmd == CMD_STEP)) begin
                    next_state_s  = START;
                    next_target_s = STEP_EXEC;
                end else if (cmd_fire_s && (i_cmd == CMD_STOP)) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: next_state_s = target_r;
            RUN: begin
                // End of program beats a simultaneous STOP or breakpoint.
                if (i_end_program) begin
                    next_state_s = DONE;
                end else if (cmd_fire_s && (i_cmd == CMD_STOP)) begin
                    next_state_s = HALT;
                end else if (bp_hit_s) begin
                    next_state_s = PAUSED;
                end else begin
                    next_state_s = RUN;
                end
            end
            STEP_EXEC: begin
                if (i_end_program) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = PAUSED;
                end
            end
            PAUSED: begin
                if (cmd_fire_s && (i_cmd == CMD_STEP)) begin
                    next_state_s = STEP_EXEC;
                end else if (cmd_fire_s && (i_cmd == CMD_RUN)) begin
                    next_state_s = RUN;
                end else if (cmd_fire_s && (i_cmd == CMD_STOP)) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = PAUSED;
                end
            end
            DONE: begin
                if (cmd_fire_s && (i_cmd == CMD_STOP)) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = DONE;
                end
            end
            HALT:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they line up with the state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= IDLE;
            target_r    <= RUN;
            o_cmd_ready <= 1'b1;
            o_pc_start  <= 1'b0;
            o_pc_halt   <= 1'b0;
            o_enable    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            target_r    <= next_target_s;
            o_cmd_ready <= (next_state_s == IDLE) || (next_state_s == RUN) ||
                           (next_state_s == PAUSED) || (next_state_s == DONE);
            o_pc_start  <= (next_state_s == START);
            o_pc_halt   <= (next_state_s == HALT);
            o_enable    <= (next_state_s == RUN) || (next_state_s == STEP_EXEC);
            o_busy      <= (next_state_s == START) || (next_state_s == RUN) ||
                           (next_state_s == STEP_EXEC) || (next_state_s == HALT);
            o_done      <= (next_state_s == DONE) && (state_r != DONE);
        end
    end

    // Executed-cycle counter: cleared on entering START, saturating count of enabled cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_cycle_count <= {CNT_SIZE{1'b0}};
        end else if (next_state_s == START) begin
            o_cycle_count <= {CNT_SIZE{1'b0}};
        end else if (o_enable && (o_cycle_count != {CNT_SIZE{1'b1}})) begin
            o_cycle_count <= o_cycle_count + {{(CNT_SIZE-1){1'b0}}, 1'b1};
        end else begin
            o_cycle_count <= o_cycle_count;
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: scenario tasks with a queue of expected cycle counts.
module tb_exec_ctrl;
    localparam int PC_SIZE  = 32;
    localparam int CNT_SIZE = 32;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STEP = 2'b10;
    localparam logic [1:0] STOP = 2'b11;

    logic                i_clk = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_cmd_valid = 1'b0;
    logic [1:0]          i_cmd = 2'b00;
    logic                o_cmd_ready;
    logic                i_end_program = 1'b0;
    logic [PC_SIZE-1:0]  i_pc = '0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
    logic                i_bp_valid = 1'b0;
    logic [PC_SIZE-1:0]  i_bp_addr = '0;
`endif
    logic                o_pc_start;
    logic                o_pc_halt;
    logic                o_enable;
    logic                o_busy;
    logic                o_done;
    logic [CNT_SIZE-1:0] o_cycle_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [CNT_SIZE-1:0] exp_q[$];
    logic [CNT_SIZE-1:0] exp_v;

    exec_ctrl #(.PC_SIZE(PC_SIZE), .CNT_SIZE(CNT_SIZE)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid),
        .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready),
        .i_end_program(i_end_program),
        .i_pc(i_pc),
`ifdef EXEC_CTRL_BREAKPOINT_EN
        .i_bp_valid(i_bp_valid),
        .i_bp_addr(i_bp_addr),
`endif
        .o_pc_start(o_pc_start),
        .o_pc_halt(o_pc_halt),
        .o_enable(o_enable),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_cycle_count(o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd = c;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd = 2'b00;
    endtask

    task automatic test_reset();
        repeat (5) tick();
        total_cnt++; if (o_cmd_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", o_cmd_ready); else pass_cnt++;
        total_cnt++; if ({o_pc_start, o_pc_halt, o_enable, o_busy, o_done} !== 5'b00000)
            $display("FAIL rst_outs: got %05b want 00000", {o_pc_start, o_pc_halt, o_enable, o_busy, o_done}); else pass_cnt++;
        total_cnt++; if (o_cycle_count !== '0) $display("FAIL rst_count: got %0d want 0", o_cycle_count); else pass_cnt++;
        i_reset = 1'b1;
        tick();
        total_cnt++; if ({o_cmd_ready, o_enable, o_busy} !== 3'b100)
            $display("FAIL post_rst: got %03b want 100", {o_cmd_ready, o_enable, o_busy}); else pass_cnt++;
    endtask

    task automatic test_run_done();
        int gaps = 0;
        exp_q.push_back(32'd20);
        exp_q.push_back(32'd20);
        send_cmd(RUN);
        total_cnt++; if ({o_pc_start, o_enable, o_cmd_ready, o_busy} !== 4'b1001)
            $display("FAIL run_start: got %04b want 1001", {o_pc_start, o_enable, o_cmd_ready, o_busy}); else pass_cnt++;
        tick();
        total_cnt++; if ({o_pc_start, o_enable} !== 2'b01)
            $display("FAIL run_first_en: got %02b want 01", {o_pc_start, o_enable}); else pass_cnt++;
        total_cnt++; if (o_cycle_count !== '0) $display("FAIL run_cnt_clear: got %0d want 0", o_cycle_count); else pass_cnt++;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (o_enable !== 1'b1) gaps++;
        end
        total_cnt++; if (gaps !== 0) $display("FAIL run_continuous: got %0d gaps want 0", gaps); else pass_cnt++;
        i_end_program = 1'b1;
        tick();
        i_end_program = 1'b0;
        total_cnt++; if ({o_done, o_enable, o_busy} !== 3'b100)
            $display("FAIL run_done: got %03b want 100", {o_done, o_enable, o_busy}); else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_cycle_count !== exp_v) $display("FAIL run_done_count: got %0d want %0d", o_cycle_count, exp_v); else pass_cnt++;
        tick();
        total_cnt++; if ({o_done, o_cmd_ready} !== 2'b01)
            $display("FAIL done_pulse_once: got %02b want 01", {o_done, o_cmd_ready}); else pass_cnt++;
        send_cmd(STOP);
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_pc_halt !== 1'b1 || o_cycle_count !== exp_v)
            $display("FAIL done_stop: halt %0b count %0d want 1 %0d", o_pc_halt, o_cycle_count, exp_v); else pass_cnt++;
        tick();
    endtask

    task automatic test_step();
        int en_total = 0;
        int width_bad = 0;
        int run_bad = 0;
        logic prev = 1'b0;
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd10);
        for (int s = 0; s < 5; s++) begin
            send_cmd(STEP);
            for (int c = 0; c < 4; c++) begin
                if (o_enable === 1'b1) begin
                    en_total++;
                    if (prev === 1'b1) width_bad++;
                end
                prev = o_enable;
                tick();
            end
        end
        total_cnt++; if (en_total !== 5) $display("FAIL step_pulses: got %0d want 5", en_total); else pass_cnt++;
        total_cnt++; if (width_bad !== 0) $display("FAIL step_width: got %0d wide want 0", width_bad); else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_cycle_count !== exp_v) $display("FAIL step_count: got %0d want %0d", o_cycle_count, exp_v); else pass_cnt++;
        total_cnt++; if ({o_cmd_ready, o_busy, o_enable} !== 3'b100)
            $display("FAIL step_paused: got %03b want 100", {o_cmd_ready, o_busy, o_enable}); else pass_cnt++;
        send_cmd(RUN);
        for (int c = 0; c < 5; c++) begin
            if (o_enable !== 1'b1) run_bad++;
            if (c < 4) tick();
        end
        total_cnt++; if (run_bad !== 0) $display("FAIL paused_run: got %0d gaps want 0", run_bad); else pass_cnt++;
        send_cmd(STOP);
        exp_v = exp_q.pop_front();
        total_cnt++; if ({o_pc_halt, o_enable} !== 2'b10 || o_cycle_count !== exp_v)
            $display("FAIL step_run_stop: halt/en %02b count %0d want 10 %0d", {o_pc_halt, o_enable}, o_cycle_count, exp_v); else pass_cnt++;
        tick();
    endtask

    task automatic test_stop();
        exp_q.push_back(32'd10);
        send_cmd(RUN);
        tick();
        repeat (9) tick();
        send_cmd(STOP);
        total_cnt++; if ({o_pc_halt, o_pc_start, o_enable, o_busy, o_cmd_ready} !== 5'b10010)
            $display("FAIL stop_halt: got %05b want 10010", {o_pc_halt, o_pc_start, o_enable, o_busy, o_cmd_ready}); else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_cycle_count !== exp_v) $display("FAIL stop_count: got %0d want %0d", o_cycle_count, exp_v); else pass_cnt++;
        tick();
        total_cnt++; if ({o_cmd_ready, o_pc_halt, o_busy} !== 3'b100 || o_cycle_count !== exp_v)
            $display("FAIL stop_idle: flags %03b count %0d want 100 %0d", {o_cmd_ready, o_pc_halt, o_busy}, o_cycle_count, exp_v); else pass_cnt++;
    endtask

    task automatic test_stop_end_same();
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd3);
        send_cmd(RUN);
        tick();
        tick();
        tick();
        i_end_program = 1'b1;
        send_cmd(STOP);
        i_end_program = 1'b0;
        total_cnt++; if ({o_done, o_pc_halt, o_enable} !== 3'b100)
            $display("FAIL same_done: got %03b want 100", {o_done, o_pc_halt, o_enable}); else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_cycle_count !== exp_v) $display("FAIL same_count: got %0d want %0d", o_cycle_count, exp_v); else pass_cnt++;
        tick();
        total_cnt++; if ({o_pc_halt, o_done, o_cmd_ready} !== 3'b001)
            $display("FAIL same_no_halt: got %03b want 001", {o_pc_halt, o_done, o_cmd_ready}); else pass_cnt++;
        send_cmd(STOP);
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_pc_halt !== 1'b1 || o_cycle_count !== exp_v)
            $display("FAIL same_stop: halt %0b count %0d want 1 %0d", o_pc_halt, o_cycle_count, exp_v); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        send_cmd(RUN);
        tick();
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        total_cnt++; if ({o_enable, o_busy, o_cmd_ready, o_pc_start} !== 4'b0010)
            $display("FAIL async_rst: got %04b want 0010", {o_enable, o_busy, o_cmd_ready, o_pc_start}); else pass_cnt++;
        total_cnt++; if (o_cycle_count !== '0) $display("FAIL async_rst_count: got %0d want 0", o_cycle_count); else pass_cnt++;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        exp_q.push_back(32'd4);
        send_cmd(RUN);
        total_cnt++; if (o_pc_start !== 1'b1 || o_cycle_count !== '0)
            $display("FAIL rerun_start: start %0b count %0d want 1 0", o_pc_start, o_cycle_count); else pass_cnt++;
        tick();
        tick();
        tick();
        tick();
        i_end_program = 1'b1;
        tick();
        i_end_program = 1'b0;
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_done !== 1'b1 || o_cycle_count !== exp_v)
            $display("FAIL rerun_done: done %0b count %0d want 1 %0d", o_done, o_cycle_count, exp_v); else pass_cnt++;
        send_cmd(STOP);
        tick();
    endtask

`ifdef EXEC_CTRL_BREAKPOINT_EN
    task automatic test_breakpoint();
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd7);
        i_bp_valid = 1'b1;
        i_bp_addr = 32'h0000_0010;
        i_pc = 32'h0000_0000;
        send_cmd(RUN);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            i_pc = i_pc + 32'd4;
        end
        tick();
        total_cnt++; if ({o_enable, o_done, o_cmd_ready} !== 3'b001)
            $display("FAIL bp_pause: got %03b want 001", {o_enable, o_done, o_cmd_ready}); else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_cycle_count !== exp_v) $display("FAIL bp_count: got %0d want %0d", o_cycle_count, exp_v); else pass_cnt++;
        send_cmd(RUN);
        total_cnt++; if (o_enable !== 1'b1) $display("FAIL bp_resume: got %0b want 1", o_enable); else pass_cnt++;
        tick();
        total_cnt++; if (o_enable !== 1'b1) $display("FAIL bp_no_retrap: got %0b want 1", o_enable); else pass_cnt++;
        i_pc = 32'h0000_0014;
        i_end_program = 1'b1;
        tick();
        i_end_program = 1'b0;
        exp_v = exp_q.pop_front();
        total_cnt++; if (o_done !== 1'b1 || o_cycle_count !== exp_v)
            $display("FAIL bp_done: done %0b count %0d want 1 %0d", o_done, o_cycle_count, exp_v); else pass_cnt++;
        i_bp_valid = 1'b0;
        send_cmd(STOP);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_run_done();
        test_step();
        test_stop();
        test_stop_end_same();
        test_reset_mid_run();
`ifdef EXEC_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
